// File: rtl/sdreq_pkg.sv
// Shared types and constants for the SDRAM request dispatcher.
package sdreq_pkg;

  localparam int NUM_CH = 4;
  localparam int CH_W   = $clog2(NUM_CH);

  // Only this channel may run the read-only 18x9 mode.
  localparam logic [CH_W-1:0] MODE_CH = CH_W'(2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2
  } state_t;

  typedef struct packed {
    logic [21:0] sa;
    logic [5:0]  param;
    logic        mode;
    logic        wnr;
  } desc_t;

endpackage

// File: rtl/sdreq_rr_arb.sv
// Four-way round-robin arbiter: searches from ptr+1 and returns a one-hot
// grant plus the index of the winner (ptr unchanged when nothing requests).
module sdreq_rr_arb
  import sdreq_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  output logic [NUM_CH-1:0] gnt,
  output logic [CH_W-1:0]   ptr_next
);

  logic            found;
  logic [CH_W-1:0] idx;

  always_comb begin
    gnt      = '0;
    ptr_next = ptr;
    found    = 1'b0;
    idx      = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = ptr + CH_W'(i);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        ptr_next = idx;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sdreq_dispatch.sv
// Initiator-side dispatcher for the SDRAM command sequencer: round-robin over
// four channels plus a postponable auto-refresh. Optional watchdog: SDREQ_WATCHDOG_EN.
module sdreq_dispatch
  import sdreq_pkg::*;
#(
  parameter int REFR_PERIOD   = 780,
  parameter int REFR_MAX_PEND = 8,
  parameter int WD_CYCLES     = 1023
) (
  input  logic                     clk0,
  input  logic                     rst,
  input  logic                     en,
  input  logic [NUM_CH-1:0]        req,
  input  logic [NUM_CH-1:0][21:0]  ch_sa,
  input  logic [NUM_CH-1:0][5:0]   ch_param,
  input  logic [NUM_CH-1:0]        ch_mode,
  input  logic [NUM_CH-1:0]        ch_wnr,
  input  logic                     next,
  output logic [NUM_CH-1:0]        ack,
  output logic                     xfer,
  output logic                     refr,
  output logic [21:0]              sa,
  output logic [CH_W-1:0]          chsel,
  output logic [5:0]               param,
  output logic                     mode,
  output logic                     wnr,
  output logic                     busy,
  output logic [3:0]               refr_pend,
  output logic                     wd_err
);

  // Handshake: xfer or refr is a one-cycle strobe (with ack for xfer) that
  // launches one operation; nothing else is launched until the sequencer
  // returns a one-cycle next while we sit in BUSY. next at any other time is dropped.

  localparam int              TMR_W      = (REFR_PERIOD > 1) ? $clog2(REFR_PERIOD) : 1;
  localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(REFR_PERIOD - 1);
  localparam logic [3:0]      PEND_MAX   = 4'(REFR_MAX_PEND);

  state_t            state_q, state_d;
  logic [CH_W-1:0]   ptr_q, ptr_nx;
  logic [NUM_CH-1:0] gnt;
  logic [TMR_W-1:0]  tmr_q;
  logic              tick, grant_ch, grant_refr, wd_timeout;
  desc_t             desc_q, desc_sel;

  sdreq_rr_arb u_arb (
    .req      (req),
    .ptr      (ptr_q),
    .gnt      (gnt),
    .ptr_next (ptr_nx)
  );

  assign tick = (tmr_q == '0);

  // A full postponement budget outranks channels; otherwise refresh only fills idle slots.
  always_comb begin
    grant_ch   = 1'b0;
    grant_refr = 1'b0;
    if (state_q == IDLE && en) begin
      if (refr_pend == PEND_MAX)   grant_refr = 1'b1;
      else if (|req)               grant_ch   = 1'b1;
      else if (refr_pend != '0)    grant_refr = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_ch || grant_refr) state_d = ISSUE;
      ISSUE:   state_d = BUSY;
      BUSY:    if (next || wd_timeout) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    desc_sel.sa    = ch_sa[ptr_nx];
    desc_sel.param = ch_param[ptr_nx];
    desc_sel.wnr   = ch_wnr[ptr_nx];
    desc_sel.mode  = (ptr_nx == MODE_CH) && !ch_wnr[ptr_nx] && ch_mode[ptr_nx];
  end

  always_ff @(negedge clk0) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(negedge clk0) begin
    if (rst) begin
      xfer   <= 1'b0;
      refr   <= 1'b0;
      ack    <= '0;
      busy   <= 1'b0;
      desc_q <= '0;
      chsel  <= '0;
      ptr_q  <= CH_W'(NUM_CH - 1);
    end else begin
      xfer <= grant_ch;
      refr <= grant_refr;
      ack  <= grant_ch ? gnt : '0;
      busy <= (state_d != IDLE);
      // A refresh grant leaves the descriptor untouched.
      if (grant_ch) begin
        desc_q <= desc_sel;
        chsel  <= ptr_nx;
        ptr_q  <= ptr_nx;
      end
    end
  end

  always_ff @(negedge clk0) begin
    if (rst) begin
      tmr_q     <= TMR_RELOAD;
      refr_pend <= '0;
    end else begin
      tmr_q <= tick ? TMR_RELOAD : tmr_q - 1'b1;
      case ({tick, grant_refr})
        2'b10:   if (refr_pend != PEND_MAX) refr_pend <= refr_pend + 1'b1;
        2'b01:   refr_pend <= refr_pend - 1'b1;
        default: refr_pend <= refr_pend;
      endcase
    end
  end

`ifdef SDREQ_WATCHDOG_EN
  localparam int WD_W = $clog2(WD_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;

  assign wd_timeout = (state_q == BUSY) && !next && (wd_cnt == WD_W'(WD_CYCLES - 1));

  always_ff @(negedge clk0) begin
    if (rst) begin
      wd_cnt <= '0;
      wd_err <= 1'b0;
    end else begin
      wd_cnt <= (state_q == BUSY) ? wd_cnt + 1'b1 : '0;
      if (wd_timeout) wd_err <= 1'b1;
    end
  end
`else
  assign wd_timeout = 1'b0;
  assign wd_err     = 1'b0;
`endif

  assign sa    = desc_q.sa;
  assign param = desc_q.param;
  assign mode  = desc_q.mode;
  assign wnr   = desc_q.wnr;

endmodule

// File: tb/tb_sdreq_dispatch.sv
// Bench for sdreq_dispatch: directed phases and random traffic against a
// transaction-level reference model; strobes are checked through a scoreboard queue.
module tb_sdreq_dispatch;

  localparam int P    = 16;
  localparam int MAXP = 2;
  localparam int WD   = 20;
  localparam int M_IDLE = 0, M_ISSUE = 1, M_BUSY = 2;

  logic             clk0 = 1'b0;
  logic             rst, en, next;
  logic [3:0]       req, ch_mode, ch_wnr;
  logic [3:0][21:0] ch_sa;
  logic [3:0][5:0]  ch_param;
  logic [3:0]       ack;
  logic             xfer, refr, mode, wnr, busy, wd_err;
  logic [21:0]      sa;
  logic [1:0]       chsel;
  logic [5:0]       param;
  logic [3:0]       refr_pend;

  always #5 clk0 = ~clk0;

  sdreq_dispatch #(.REFR_PERIOD(P), .REFR_MAX_PEND(MAXP), .WD_CYCLES(WD)) dut (
    .clk0(clk0), .rst(rst), .en(en), .req(req), .ch_sa(ch_sa), .ch_param(ch_param),
    .ch_mode(ch_mode), .ch_wnr(ch_wnr), .next(next), .ack(ack), .xfer(xfer), .refr(refr),
    .sa(sa), .chsel(chsel), .param(param), .mode(mode), .wnr(wnr), .busy(busy),
    .refr_pend(refr_pend), .wd_err(wd_err)
  );

  int  checks = 0;
  int  failures = 0;
  bit  done = 0;
  logic [36:0] exp_q[$];

  // reference model state
  int          m_state, m_pend, m_ptr, m_edge, m_wd, m_gch;
  bit          m_wd_err, m_grefr;
  logic [21:0] m_sa;
  logic [1:0]  m_chsel;
  logic [5:0]  m_param;
  logic        m_mode, m_wnr;

  // stimulus knobs
  bit rand_req = 0, refill_all = 0, hold_next = 0;
  int dly_lo = 4, dly_hi = 4, nt = -1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [36:0] pack_strobe(input logic r, input logic [3:0] a,
      input logic [21:0] s, input logic [1:0] c, input logic [5:0] p, input logic md,
      input logic w);
    return {r, a, s, c, p, md, w};
  endfunction

  task automatic model_reset();
    m_state = M_IDLE; m_pend = 0; m_ptr = 3; m_edge = 0; m_wd = 0; m_wd_err = 0;
    m_sa = '0; m_chsel = '0; m_param = '0; m_mode = 0; m_wnr = 0;
  endtask

  // Applies the rules to the inputs that were present at the falling edge just past.
  task automatic model_step();
    bit tick;
    int c;
    m_gch = -1;
    m_grefr = 0;
    if (rst) begin
      model_reset();
      return;
    end
    tick = (m_edge % P) == P - 1;
    m_edge++;
    case (m_state)
      M_IDLE: if (en) begin
        if (m_pend == MAXP) m_grefr = 1;
        else if (req != 0) begin
          for (int k = 1; k <= 4; k++) begin
            c = (m_ptr + k) % 4;
            if (m_gch < 0 && req[c]) m_gch = c;
          end
        end else if (m_pend != 0) m_grefr = 1;
        if (m_grefr || m_gch >= 0) m_state = M_ISSUE;
      end
      M_ISSUE: begin
        m_state = M_BUSY;
        m_wd = 0;
      end
      default: if (next) m_state = M_IDLE;
      else begin
        m_wd++;
`ifdef SDREQ_WATCHDOG_EN
        if (m_wd == WD) begin
          m_wd_err = 1;
          m_state = M_IDLE;
        end
`endif
      end
    endcase
    if (m_grefr && !tick) m_pend--;
    else if (!m_grefr && tick && m_pend < MAXP) m_pend++;
    if (m_gch >= 0) begin
      m_sa = ch_sa[m_gch];
      m_chsel = 2'(m_gch);
      m_param = ch_param[m_gch];
      m_wnr = ch_wnr[m_gch];
      m_mode = (m_gch == 2 && !ch_wnr[2]) ? ch_mode[2] : 1'b0;
      m_ptr = m_gch;
      exp_q.push_back(pack_strobe(1'b0, 4'(1 << m_gch), m_sa, m_chsel, m_param, m_mode, m_wnr));
    end
    if (m_grefr)
      exp_q.push_back(pack_strobe(1'b1, 4'b0, m_sa, m_chsel, m_param, m_mode, m_wnr));
  endtask

  task automatic check_zero(input string name);
    chk(name, {xfer, refr, ack, sa, chsel, param, mode, wnr, busy, refr_pend, wd_err}, 64'd0);
  endtask

  // One clock: evaluate the model, check status, then drive the next inputs.
  task automatic cycle();
    @(posedge clk0);
    model_step();
    chk("busy", 64'(busy), 64'(m_state != M_IDLE));
    chk("refr_pend", 64'(refr_pend), 64'(m_pend));
    chk("wd_err", 64'(wd_err), 64'(m_wd_err));
    chk("desc_hold", 64'({sa, chsel, param, mode, wnr}),
        64'({m_sa, m_chsel, m_param, m_mode, m_wnr}));
    if (m_gch >= 0) req[m_gch] = 1'b0;
    if (refill_all) req = 4'hF;
    else if (rand_req) begin
      for (int i = 0; i < 4; i++) begin
        if (!req[i] && $urandom_range(0, 3) == 0) req[i] = 1'b1;
        ch_sa[i] = 22'($urandom);
        ch_param[i] = 6'($urandom);
      end
      ch_mode = 4'($urandom);
      ch_wnr = 4'($urandom);
      en = ($urandom_range(0, 15) != 0);
    end
    if (m_state == M_BUSY && !hold_next) begin
      if (nt < 0) nt = $urandom_range(dly_hi, dly_lo);
      if (nt == 0) begin
        next = 1'b1;
        nt = -1;
      end else begin
        next = 1'b0;
        nt--;
      end
    end else if (m_state == M_BUSY) begin
      next = 1'b0;
    end else begin
      next = ($urandom_range(0, 7) == 0);
      nt = -1;
    end
  endtask

  initial begin : monitor
    logic [36:0] got;
    while (!done) begin
      @(posedge clk0);
      #1;
      if (xfer === 1'b1 || refr === 1'b1) begin
        got = {refr, ack, sa, chsel, param, mode, wnr};
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL strobe_unexpected got=%h exp=none t=%0t", got, $time);
        end else begin
          chk("strobe", 64'(got), 64'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin : driver
    bit reached;
    rst = 1; en = 0; next = 0; req = '0;
    ch_sa = '0; ch_param = '0; ch_mode = '0; ch_wnr = '0;
    model_reset();
    @(negedge clk0);
    repeat (3) cycle();
    check_zero("reset_outputs");
    rst = 0;
    en = 1;

    // single request on channel 0
    ch_sa[0] = 22'h12345; ch_wnr[0] = 1'b1; ch_param[0] = 6'h2A; req = 4'b0001;
    repeat (14) cycle();
    chk("single_sa", 64'(sa), 64'h12345);
    chk("single_chsel", 64'(chsel), 64'd0);

    // continuous requests: round robin plus forced refresh
    refill_all = 1; req = 4'hF;
    repeat (90) cycle();
    refill_all = 0; req = '0;
    repeat (8) cycle();

    // mode forcing
    ch_mode = 4'hF; ch_wnr = 4'b0000; req = 4'b0010;
    repeat (16) cycle();
    chk("mode_ch1", 64'(mode), 64'd0);
    ch_wnr[2] = 1'b1; req = 4'b0100;
    repeat (16) cycle();
    chk("mode_ch2_write", 64'(mode), 64'd0);
    chk("chsel_ch2", 64'(chsel), 64'd2);
    ch_wnr[2] = 1'b0; req = 4'b0100;
    repeat (16) cycle();
    chk("mode_ch2_read", 64'(mode), 64'd1);

    // idle channels: periodic refresh
    req = '0;
    repeat (60) cycle();

    // dispatch disabled: no grants, pending refreshes saturate
    en = 0; req = 4'hF;
    repeat (40) cycle();
    chk("en_low_idle", 64'(busy), 64'd0);
    chk("en_low_pend", 64'(refr_pend), 64'(MAXP));
    en = 1;
    repeat (30) cycle();

    // random traffic
    rand_req = 1; dly_lo = 0; dly_hi = 6;
    repeat (1500) cycle();
    rand_req = 0; en = 1;

    // next withheld
    req = 4'b0001; hold_next = 1;
    repeat (45) cycle();
`ifdef SDREQ_WATCHDOG_EN
    chk("wd_sticky", 64'(wd_err), 64'd1);
`else
    chk("busy_waits", 64'(busy), 64'd1);
`endif
    hold_next = 0;
    repeat (12) cycle();

    // reset while BUSY
    req = 4'b0001; hold_next = 1; reached = 0;
    for (int i = 0; i < 30 && !reached; i++) begin
      cycle();
      if (m_state == M_BUSY) reached = 1;
    end
    chk("reach_busy", 64'(busy), 64'd1);
    rst = 1;
    cycle();
    check_zero("rst_in_busy");
    rst = 0; hold_next = 0; req = '0;
    repeat (50) cycle();

    done = 1;
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sdreq_dispatch.md
# sdreq_dispatch

Request dispatcher that drives the `xfer`/`refr`/`next` handshake of the SDRAM command sequencer from the initiator side. It arbitrates four channel descriptors round-robin and runs a periodic auto-refresh timer with bounded postponement. For each granted operation it presents one registered descriptor (`sa`, `chsel`, `param`, `mode`, `wnr`) with a single-cycle `xfer` or `refr` strobe. It then holds until the sequencer answers with `next`.

## Interface
Parameters:
- REFR_PERIOD, 780 — clk0 cycles between refresh ticks
- REFR_MAX_PEND, 8 — maximum postponed refreshes; reaching it forces a refresh
- WD_CYCLES, 1023 — watchdog limit in BUSY (used only with the watchdog macro)

Ports:
- clk0  in  1  — single clock; all registers update on the falling edge, same as the sequencer
- rst  in  1  — reset; synchronous and active-high
- en  in  1  — dispatch enable; when low, no new grants are made and an operation in flight completes
- req  in  4  — per-channel request, level-held until acked
- ch_sa  in  4×22  — per-channel start address [24:3]
- ch_param  in  4×6  — per-channel param
- ch_mode  in  4  — per-channel mode (1 = 18x9)
- ch_wnr  in  4  — per-channel write-not-read
- next  in  1  — sequencer ready for the next request (1-cycle pulse)
- ack  out  4  — one-hot grant pulse, coincident with `xfer`
- xfer  out  1  — start block transfer, 1 cycle
- refr  out  1  — start auto refresh, 1 cycle
- sa  out  22  — registered descriptor field
- chsel  out  2  — registered descriptor field
- param  out  6  — registered descriptor field
- mode  out  1  — registered descriptor field
- wnr  out  1  — registered descriptor field
- busy  out  1  — operation outstanding
- refr_pend  out  4  — postponed-refresh count
- wd_err  out  1  — sticky watchdog error

## Operation
- States:
  - IDLE: evaluate a grant each cycle.
  - ISSUE: one cycle; `xfer` or `refr` = 1.
  - BUSY: wait for `next`.
- IDLE→ISSUE when `en` = 1 and a candidate exists. ISSUE→BUSY unconditionally. BUSY→IDLE on `next` = 1.
- Candidate priority:
  1. Refresh, if `refr_pend` = REFR_MAX_PEND.
  2. Channel requests, round-robin, searching from last granted + 1 (mod 4).
  3. Refresh, if `refr_pend` ≠ 0 and no `req` is set.
- Descriptor outputs load on the IDLE→ISSUE edge and hold stable until the next load.
- `mode` is forced to 0 unless `chsel` = 2 and `wnr` = 0, because 18x9 mode is read-only and channel 2 only.
- Refresh grant: `sa`, `chsel`, `param`, `mode`, `wnr` keep their previous values; only `refr` pulses.
- Refresh timer: a down-counter reloads to REFR_PERIOD−1 at 0.
  - Each reload is a tick; a tick increments `refr_pend`, saturating at REFR_MAX_PEND.
  - A refresh grant decrements `refr_pend`.
  - A tick and a grant in the same cycle leave `refr_pend` unchanged.
- `next` received outside BUSY is ignored.
- `en` deasserted while in ISSUE or BUSY does not abort; the FSM returns to IDLE and stalls there.

## Timing
- Reset values: state IDLE; all outputs 0; refresh counter = REFR_PERIOD−1; round-robin pointer = 3, so channel 0 wins first.
- A request visible in IDLE at edge N produces `xfer`, `ack`, and valid descriptor at edge N+1.
- `busy` = 1 in ISSUE and BUSY.
- `next` sampled at edge M returns the FSM to IDLE at M+1. The earliest following strobe is at M+2.
- `rst` mid-operation aborts to IDLE within the same edge and clears `refr_pend` and `wd_err`. The sequencer shares `rst`.

## Configuration
- SDREQ_WATCHDOG_EN defined:
  - A counter runs in BUSY.
  - If `next` has not arrived after WD_CYCLES cycles, `wd_err` is set (sticky until `rst`) and the FSM returns to IDLE.
- SDREQ_WATCHDOG_EN undefined: no counter, `wd_err` is tied to 0, and BUSY waits indefinitely.

## Structure
- Shared package `sdreq_pkg`:
  - FSM state enum (IDLE, ISSUE, BUSY)
  - channel-count constant (4)
  - descriptor struct {sa[24:3], param[5:0], mode, wnr}
- One natural sub-module: `sdreq_rr_arb`, a 4-way round-robin arbiter that outputs a one-hot grant and the updated pointer.

## Test plan
- **Single request:** `req` = 0001, `ch_sa[0]` = 0x12345, `wnr` = 1 → one `xfer` with `ack` = 0001, `sa` = 0x12345, `chsel` = 0. `busy` stays high until `next`; `xfer` is not repeated.
- **Round robin:** all `req` = 1111 with `next` returned 5 cycles after each strobe → grant order 0,1,2,3,0.
- **Mode forcing:** `req[1]` with mode = 1 → `mode` = 0. `req[2]` with mode = 1, wnr = 1 → `mode` = 0. `req[2]` with mode = 1, wnr = 0 → `mode` = 1.
- **Refresh with idle channels:** REFR_PERIOD = 16, no `req` → `refr` pulses every 16 cycles and `refr_pend` returns to 0 after each grant.
- **Refresh starvation bound:** continuous `req` = 1111, REFR_MAX_PEND = 2 → `refr` is issued in the first IDLE after `refr_pend` reaches 2, ahead of pending channels.
- **Watchdog and reset:** with SDREQ_WATCHDOG_EN, WD_CYCLES = 20, `next` withheld → `wd_err` = 1 on cycle 20 of BUSY, then the FSM is IDLE. Asserting `rst` in BUSY → all outputs are 0 on the next edge.
